// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NREQ byte producers.
// Each grant issues a 1-cycle tx_start and then holds off new grants for a fixed frame time.
module uart_tx_arbiter #(
  parameter int NREQ         = 4,
  parameter int FRAME_CYCLES = 3132,
  parameter int CW           = 12,
  localparam int PW          = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic              tx_enable,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              busy,
  output logic [PW-1:0]     grant_id,
  output logic [1:0]        state_dbg
);

  // Handshake: a requester raises req_valid with stable req_data and holds both
  // until it sees its req_ready pulse; the byte is taken in the cycle that pulse
  // is high. The requester drops valid or presents its next byte the cycle after.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [PW:0]   NREQ_W = (PW+1)'(NREQ);
  localparam logic [PW-1:0] LAST   = PW'(NREQ - 1);

  state_t          state, state_next;
  logic [CW-1:0]   counter, counter_next;
  logic [PW-1:0]   rr_ptr, rr_next;
  logic [7:0]      tx_data_next;
  logic [PW-1:0]   grant_next;
  logic            tx_start_next;
  logic [NREQ-1:0] req_ready_next;
  logic            busy_next;
  logic            win_found;
  logic [PW-1:0]   win_idx;
  logic [PW:0]     cand;

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + (PW+1)'(k);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!win_found && req_valid[cand[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    state_next     = state;
    counter_next   = counter;
    rr_next        = rr_ptr;
    tx_data_next   = tx_data;
    grant_next     = grant_id;
    tx_start_next  = 1'b0;
    req_ready_next = '0;
    busy_next      = 1'b0;
    case (state)
      IDLE: begin
        if (tx_enable && win_found) begin
          state_next              = ISSUE;
          tx_data_next            = req_data[{win_idx, 3'b000} +: 8];
          grant_next              = win_idx;
          tx_start_next           = 1'b1;
          req_ready_next[win_idx] = 1'b1;
          busy_next               = 1'b1;
        end
      end
      ISSUE: begin
        state_next   = WAIT;
        counter_next = CW'(FRAME_CYCLES - 1);
        rr_next      = (grant_id == LAST) ? '0 : grant_id + PW'(1);
        busy_next    = 1'b1;
      end
      WAIT: begin
        // Counter runs FRAME_CYCLES-1 down to 0, so WAIT spans FRAME_CYCLES cycles.
        if (counter == '0) begin
          state_next = IDLE;
        end else begin
          counter_next = counter - CW'(1);
          busy_next    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      counter   <= '0;
      rr_ptr    <= '0;
      tx_data   <= '0;
      grant_id  <= '0;
      tx_start  <= 1'b0;
      req_ready <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      counter   <= counter_next;
      rr_ptr    <= rr_next;
      tx_data   <= tx_data_next;
      grant_id  <= grant_next;
      tx_start  <= tx_start_next;
      req_ready <= req_ready_next;
      busy      <= busy_next;
    end
  end

  assign state_dbg = state;

endmodule
